// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Contents:
//   arb_state_t  arbiter FSM state encoding (IDLE, ACCESS, RESP)
//   RW_READ/RW_WRITE  values of the rw signal on master and memory ports
//   DEF_*        default widths and timeout
//   CNT_W        width of the wait/timeout counter
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 15;

  // Timeout counter width; TIMEOUT must therefore stay within 1..255.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker (purely combinational).
// Ports:
//   req         request vector, bit i = master i
//   last_grant  index of the master granted most recently
//   grant       index of the master to grant now; only meaningful when |req
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = last_grant;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      // On a tie the master that did not go last wins, so neither starves.
      2'b11:   grant = ~last_grant;
      default: grant = last_grant;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of one single-ported memory. One transaction is
// in flight at a time; ties are broken round-robin; an access that memory never
// acknowledges is aborted after TIMEOUT cycles and reported with err.
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   m0_*/m1_*                    master req/rw/addr/wdata in, rdata/done/err out
//   mem_valid/rw/addr/wdata      registered memory request
//   mem_rdata, mem_ready         memory response
// Every output comes straight from a flop.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  // master 0 (cpu)
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_err,
  // master 1 (loader / DMA)
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_err,
  // memory side
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // Last non-ready cycle before the abort: counter value TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q;
  logic             last_grant_q;
  logic             owner_q;      // master currently being served
  logic [CNT_W-1:0] cnt_q;

  logic [1:0] req;
  logic       pick;

  assign req = {m1_req, m0_req};

  rr_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // master 0 wins the first tie
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      mem_valid    <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
    end else begin
      // done/err are single-cycle pulses, only raised on the way into RESP.
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q      <= pick;
            last_grant_q <= pick;
            cnt_q        <= '0;
            mem_valid    <= 1'b1;
            mem_rw       <= pick ? m1_rw    : m0_rw;
            mem_addr     <= pick ? m1_addr  : m0_addr;
            mem_wdata    <= pick ? m1_wdata : m0_wdata;
            state_q      <= ACCESS;
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            if (mem_rw == RW_READ) begin
              if (owner_q) m1_rdata <= mem_rdata;
              else         m0_rdata <= mem_rdata;
            end
            if (owner_q) m1_done <= 1'b1;
            else         m0_done <= 1'b1;
            mem_valid <= 1'b0;
            state_q   <= RESP;
          end else if (cnt_q == TO_LAST) begin
            // Abort: report an error and leave the owner's rdata untouched.
            if (owner_q) begin
              m1_done <= 1'b1;
              m1_err  <= 1'b1;
            end else begin
              m0_done <= 1'b1;
              m0_err  <= 1'b1;
            end
            mem_valid <= 1'b0;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q   <= IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master memory bus arbiter between the `cpu` core's memory port (master 0) and a second bus master such as a loader or DMA engine (master 1), both sharing one single-ported memory. Each master gets a req/done handshake with a registered read-data return. Access is granted round-robin on contention, one transaction is in flight at a time, and an access that is never acknowledged ends with an error flag instead of hanging the bus.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 15: cycles to wait for `mem_ready` before aborting with an error. Range 1..255.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  transaction request; held high until the matching done.
- `m0_rw`, `m1_rw`  in  1  access type: 1 = read, 0 = write.
- `m0_addr`, `m1_addr`  in  ADDR_W  access address.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_rdata`, `m1_rdata`  out  DATA_W  registered read data; valid in the done cycle and held until that master's next done.
- `m0_done`, `m1_done`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  high together with done when the access timed out.
- `mem_valid`  out  1  memory access strobe.
- `mem_rw`  out  1  access type to memory (1 = read).
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; sampled when `mem_valid` and `mem_ready` are both high.
- `mem_ready`  in  1  memory acknowledge; ignored while `mem_valid` is low.

## Operation
- FSM has three states: IDLE, ACCESS, RESP. Reset value is IDLE.
- IDLE:
  - Samples `m0_req` and `m1_req`. If neither is high, it stays in IDLE.
  - With one request, that master is granted.
  - With both, the master not in `last_grant` is granted.
  - On grant, `rw`, `addr` and `wdata` are latched into the bus registers, `last_grant` is updated, the timeout counter is cleared, and the FSM moves to ACCESS.
- ACCESS:
  - `mem_valid` = 1; the bus registers drive `mem_rw`, `mem_addr` and `mem_wdata`.
  - If `mem_ready` = 1: on a read, `mem_rdata` is latched into the granted master's rdata register. The FSM moves to RESP with err = 0.
  - Otherwise the counter increments. When it reaches TIMEOUT, the FSM moves to RESP with err = 1 and rdata is left unchanged.
- RESP:
  - The granted master's done is 1, and its err is set as decided in ACCESS.
  - `mem_valid` = 0. The FSM always returns to IDLE.
- Requester rule: drop req at the edge that ends the done cycle. A req still high in the following IDLE cycle is a new transaction.
- A req that rises while the other master is being served waits in IDLE arbitration. Because grants alternate on ties, neither master is starved.
- The non-granted master's done, err and rdata are never disturbed.
- Reset values:
  - state = IDLE; `last_grant` = 1, so master 0 wins the first tie.
  - Counter = 0; `mem_valid`, `mem_rw`, `mem_addr`, `mem_wdata` = 0.
  - All done and err outputs = 0; both rdata registers = 0.
- Reset asserted mid-transaction aborts it immediately, with no done pulse.
- Width rules: the counter is 8 bits, and the comparison is counter == TIMEOUT − 1 on a non-ready cycle. No address arithmetic is performed.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Request sampled in IDLE at edge 0 → `mem_valid` is high in cycle 1.
- `mem_ready` high in cycle 1 → done in cycle 2 (minimum latency 2 cycles), then IDLE in cycle 3.
- With W wait cycles, done occurs in cycle 2 + W.
- Timeout: with `mem_ready` held low, `mem_valid` stays high for exactly TIMEOUT cycles (1..TIMEOUT), and done with err occurs in cycle TIMEOUT + 1.
- Back-to-back contended transactions occupy 3 cycles each at zero wait states.

## Structure
- Package `bus_pkg`:
  - State enum `arb_state_t` {IDLE, ACCESS, RESP}.
  - Constants `RW_READ` = 1 and `RW_WRITE` = 0.
  - Default widths.
- Sub-module `rr_pick2`: combinational two-input round-robin picker. Inputs are `req[1:0]` and `last_grant`; output is the grant index. This is its only natural split.
- The counter and bus registers stay in the top.

## Test plan
- Single read: `m0_req` read at addr 0x10; memory answers 0xDEADBEEF with ready in the first cycle → `m0_done` in cycle 2, `m0_rdata` = 0xDEADBEEF, `m0_err` = 0, `m1_*` unchanged.
- Write with 3 wait states: `m1` write of 0x1234 to 0x20 → `mem_valid`, `mem_rw` = 0, `mem_addr` = 0x20 and `mem_wdata` = 0x1234 held for 4 cycles; `m1_done` one cycle after ready.
- Contention: both masters request continuously after reset → grants alternate m0, m1, m0, m1, each done 3 cycles apart.
- Timeout: TIMEOUT = 4, `mem_ready` tied low → `mem_valid` high for exactly 4 cycles; then `m0_done` = 1 and `m0_err` = 1, and `m0_rdata` keeps its previous value.
- Reset mid-access: assert `reset` low during ACCESS → `mem_valid` is 0 immediately, no done pulse, and after release the first tie goes to m0.
- Ready without valid: `mem_ready` pulsed while IDLE → no state change and no done.
